kmap_lut_ctrl: RTL and testbench

- Programmable 4-input truth-table evaluator plus its controller: holds a 16-entry function table, configures it, and sequences single evaluations or full 16-point sweeps through a valid/ready response channel.
- Sits beside the fixed K-map combinational blocks as their run-time-reconfigurable replacement.
- The power-on function is odd parity of {a,b,c,d}.

---
 rtl/kmap_lut_ctrl.sv | 173 +++++++++++++++++
 tb/tb_kmap_lut_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/kmap_lut_ctrl.sv
// Run-time programmable 4-input truth-table evaluator with single-request and 16-point sweep sequencing.
// Optional feature: define KMAP_LUT_SWEEP_POPCNT_EN to add the sweep_ones popcount output.
module kmap_lut_ctrl #(
  parameter logic [15:0] RESET_TABLE = 16'h6996
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cfg_valid,
  input  logic [15:0] cfg_table,
  output logic        cfg_ready,
  input  logic        req_valid,
  input  logic [3:0]  req_abcd,
  output logic        req_ready,
  input  logic        sweep_start,
  output logic        sweep_busy,
  output logic        sweep_done,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [3:0]  resp_abcd,
  output logic        resp_dout
`ifdef KMAP_LUT_SWEEP_POPCNT_EN
  ,
  output logic [4:0]  sweep_ones
`endif
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESP  = 2'd1,
    S_SWEEP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] table_q, table_d;
  logic        resp_valid_q, resp_valid_d;
  logic [3:0]  resp_abcd_q, resp_abcd_d;
  logic        resp_dout_q, resp_dout_d;
  logic        sweep_busy_q, sweep_busy_d;
  logic        sweep_done_q, sweep_done_d;
  logic [3:0]  idx_q, idx_d;
  logic [3:0]  idx_nxt_s;
  logic        idle_s;

  assign idle_s    = (state_q == S_IDLE);
  assign idx_nxt_s = idx_q + 4'd1;

  // Ready is a decode of the registered state, qualified by the IDLE priority order.
  assign cfg_ready  = idle_s;
  assign req_ready  = idle_s && !cfg_valid && !sweep_start;
  assign resp_valid = resp_valid_q;
  assign resp_abcd  = resp_abcd_q;
  assign resp_dout  = resp_dout_q;
  assign sweep_busy = sweep_busy_q;
  assign sweep_done = sweep_done_q;

  always_comb begin
    state_d      = state_q;
    table_d      = table_q;
    resp_valid_d = resp_valid_q;
    resp_abcd_d  = resp_abcd_q;
    resp_dout_d  = resp_dout_q;
    sweep_busy_d = sweep_busy_q;
    sweep_done_d = 1'b0;
    idx_d        = idx_q;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          table_d = cfg_table;
        end else if (sweep_start) begin
          state_d      = S_SWEEP;
          idx_d        = 4'd0;
          resp_valid_d = 1'b1;
          resp_abcd_d  = 4'd0;
          resp_dout_d  = table_q[0];
          sweep_busy_d = 1'b1;
        end else if (req_valid) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_abcd_d  = req_abcd;
          resp_dout_d  = table_q[req_abcd];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end else begin
          state_d = S_RESP;
        end
      end
      S_SWEEP: begin
        if (resp_ready) begin
          if (idx_q == 4'd15) begin
            state_d      = S_IDLE;
            resp_valid_d = 1'b0;
            sweep_busy_d = 1'b0;
            sweep_done_d = 1'b1;
            idx_d        = 4'd0;
          end else begin
            idx_d       = idx_nxt_s;
            resp_abcd_d = idx_nxt_s;
            resp_dout_d = table_q[idx_nxt_s];
          end
        end else begin
          state_d = S_SWEEP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      table_q      <= RESET_TABLE;
      resp_valid_q <= 1'b0;
      resp_abcd_q  <= 4'd0;
      resp_dout_q  <= 1'b0;
      sweep_busy_q <= 1'b0;
      sweep_done_q <= 1'b0;
      idx_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      table_q      <= table_d;
      resp_valid_q <= resp_valid_d;
      resp_abcd_q  <= resp_abcd_d;
      resp_dout_q  <= resp_dout_d;
      sweep_busy_q <= sweep_busy_d;
      sweep_done_q <= sweep_done_d;
      idx_q        <= idx_d;
    end
  end

`ifdef KMAP_LUT_SWEEP_POPCNT_EN
  logic [4:0] acc_q, acc_d;
  logic [4:0] ones_q, ones_d;

  assign sweep_ones = ones_q;

  // The last accepted response is folded in directly so the published count covers all 16 points.
  always_comb begin
    acc_d  = acc_q;
    ones_d = ones_q;
    if (idle_s && !cfg_valid && sweep_start) begin
      acc_d = 5'd0;
    end else if ((state_q == S_SWEEP) && resp_ready) begin
      if (idx_q == 4'd15) begin
        ones_d = acc_q + {4'd0, resp_dout_q};
        acc_d  = 5'd0;
      end else begin
        acc_d = acc_q + {4'd0, resp_dout_q};
      end
    end else begin
      acc_d = acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_q  <= 5'd0;
      ones_q <= 5'd0;
    end else begin
      acc_q  <= acc_d;
      ones_q <= ones_d;
    end
  end
`endif

endmodule

// File: tb/tb_kmap_lut_ctrl.sv
// Self-checking bench for kmap_lut_ctrl: queue-based response model plus directed literal checks.
module tb_kmap_lut_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cfg_valid;
  logic [15:0] cfg_table;
  logic        cfg_ready;
  logic        req_valid;
  logic [3:0]  req_abcd;
  logic        req_ready;
  logic        sweep_start;
  logic        sweep_busy;
  logic        sweep_done;
  logic        resp_valid;
  logic        resp_ready;
  logic [3:0]  resp_abcd;
  logic        resp_dout;
`ifdef KMAP_LUT_SWEEP_POPCNT_EN
  logic [4:0]  sweep_ones;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  kmap_lut_ctrl dut (
    .clk(clk), .resetn(resetn),
    .cfg_valid(cfg_valid), .cfg_table(cfg_table), .cfg_ready(cfg_ready),
    .req_valid(req_valid), .req_abcd(req_abcd), .req_ready(req_ready),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_abcd(resp_abcd), .resp_dout(resp_dout)
`ifdef KMAP_LUT_SWEEP_POPCNT_EN
    , .sweep_ones(sweep_ones)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 single response, 2 sweep; q holds indices still owed to the consumer.
  int         m_mode  = 0;
  bit         m_armed = 0;
  bit         m_done  = 0;
  logic [15:0] m_tbl  = 16'h6996;
  logic [3:0] m_q[$];
  int         m_acc   = 0;
  int         m_ones  = 0;

  always @(negedge clk) begin
    if (m_armed) begin
      chk("m_resp_valid", resp_valid, (m_mode != 0));
      chk("m_sweep_busy", sweep_busy, (m_mode == 2));
      chk("m_sweep_done", sweep_done, m_done);
      chk("m_cfg_ready", cfg_ready, (m_mode == 0));
      chk("m_req_ready", req_ready, (m_mode == 0) && !cfg_valid && !sweep_start);
      if (m_mode != 0 && m_q.size() > 0) begin
        chk("m_resp_abcd", resp_abcd, m_q[0]);
        chk("m_resp_dout", resp_dout, m_tbl[m_q[0]]);
      end
`ifdef KMAP_LUT_SWEEP_POPCNT_EN
      chk("m_sweep_ones", sweep_ones, m_ones);
`endif
    end
    m_done = 0;
    if (!resetn) begin
      m_mode = 0; m_tbl = 16'h6996; m_q.delete(); m_acc = 0; m_ones = 0; m_armed = 1;
    end else if (m_armed) begin
      if (m_mode == 0) begin
        if (cfg_valid) m_tbl = cfg_table;
        else if (sweep_start) begin
          m_mode = 2; m_acc = 0;
          for (int i = 0; i < 16; i++) m_q.push_back(4'(i));
        end else if (req_valid) begin
          m_mode = 1; m_q.push_back(req_abcd);
        end
      end else if (resp_ready && m_q.size() > 0) begin
        if (m_mode == 2) m_acc += int'(m_tbl[m_q[0]]);
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          if (m_mode == 2) begin m_done = 1; m_ones = m_acc; end
          m_mode = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cfg(input logic [15:0] t);
    cfg_valid = 1'b1; cfg_table = t;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_req(input logic [3:0] a, input logic exp_dout);
    req_valid = 1'b1; req_abcd = a; resp_ready = 1'b1;
    #1 chk("req_ready_idle", req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
    chk("req_lat_valid", resp_valid, 1'b1);
    chk("req_abcd", resp_abcd, a);
    chk("req_dout", resp_dout, exp_dout);
    tick();
    chk("req_back_idle", resp_valid, 1'b0);
    chk("req_ready_after", req_ready, 1'b1);
  endtask

  task automatic wait_done(input int lim);
    bit seen = 0;
    for (int k = 0; k < lim && !seen; k++) begin
      tick();
      if (sweep_done) seen = 1;
    end
    chk("sweep_done_seen", seen, 1'b1);
  endtask

  logic [15:0] par;

  initial begin
    par = 16'h6996;
    resetn = 1'b0; cfg_valid = 1'b0; cfg_table = 16'h0000; req_valid = 1'b0;
    req_abcd = 4'd0; sweep_start = 1'b0; resp_ready = 1'b1;
    tick(); tick();
    resetn = 1'b1;
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_busy", sweep_busy, 1'b0);
    chk("rst_done", sweep_done, 1'b0);
    chk("rst_cfg_ready", cfg_ready, 1'b1);

    // Parity table after reset.
    do_req(4'h1, 1'b1);
    do_req(4'h3, 1'b0);

    // cfg wins over sweep_start and req in the same cycle.
    cfg_valid = 1'b1; cfg_table = 16'h8000; sweep_start = 1'b1; req_valid = 1'b1; req_abcd = 4'h5;
    #1 chk("prio_req_ready", req_ready, 1'b0);
    chk("prio_cfg_ready", cfg_ready, 1'b1);
    tick();
    cfg_valid = 1'b0; sweep_start = 1'b0; req_valid = 1'b0;
    chk("prio_no_resp", resp_valid, 1'b0);
    chk("prio_no_sweep", sweep_busy, 1'b0);
    do_req(4'hF, 1'b1);
    do_req(4'hE, 1'b0);
    do_cfg(16'h6996);

    // Full-rate sweep.
    sweep_start = 1'b1; resp_ready = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("sw_valid", resp_valid, 1'b1);
      chk("sw_abcd", resp_abcd, i);
      chk("sw_dout", resp_dout, par[i]);
      chk("sw_no_done", sweep_done, 1'b0);
      tick();
    end
    chk("sw_done", sweep_done, 1'b1);
    chk("sw_busy_fall", sweep_busy, 1'b0);
    chk("sw_valid_fall", resp_valid, 1'b0);
`ifdef KMAP_LUT_SWEEP_POPCNT_EN
    chk("sw_ones", sweep_ones, 5'd8);
`endif
    tick();
    chk("sw_done_pulse", sweep_done, 1'b0);

    // Stall at index 7 with a cfg attempt during the stall.
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    chk("stall_at7", resp_abcd, 4'd7);
    resp_ready = 1'b0; cfg_valid = 1'b1; cfg_table = 16'h0000;
    #1 chk("stall_cfg_ready", cfg_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_abcd", resp_abcd, 4'd7);
      chk("stall_dout", resp_dout, 1'b1);
    end
    cfg_valid = 1'b0; resp_ready = 1'b1;
    wait_done(20);
    tick();
    do_req(4'h1, 1'b1);

    // Reset mid-sweep after a reconfiguration.
    do_cfg(16'h0000);
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("rst_at10", resp_abcd, 4'd10);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("mrst_valid", resp_valid, 1'b0);
    chk("mrst_busy", sweep_busy, 1'b0);
    chk("mrst_done", sweep_done, 1'b0);
    chk("mrst_cfg_ready", cfg_ready, 1'b1);
`ifdef KMAP_LUT_SWEEP_POPCNT_EN
    chk("mrst_ones", sweep_ones, 5'd0);
`endif
    tick();
    chk("mrst_no_done", sweep_done, 1'b0);
    do_req(4'h1, 1'b1);

    // Single request held for 5 stalled cycles.
    req_valid = 1'b1; req_abcd = 4'h7; resp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", resp_valid, 1'b1);
      chk("hold_dout", resp_dout, 1'b1);
      chk("hold_req_ready", req_ready, 1'b0);
      tick();
    end
    resp_ready = 1'b1;
    #1 chk("hold_req_ready_last", req_ready, 1'b0);
    tick();
    chk("hold_released", resp_valid, 1'b0);
    chk("hold_req_ready_back", req_ready, 1'b1);

    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
